// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the byte-addressed data memory.
//   access_size_t : request size encoding (byte/half/word/double)
//   state_t       : controller states (zero sweep, normal operation)
//   laneMask()    : byte-lane write mask for a given size and byte offset
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } access_size_t;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Bytes touched by an access of the given size, starting at the given offset
  function automatic logic [7:0] laneMask(input access_size_t size, input logic [2:0] offset);
    logic [7:0] base;
    base = 8'h00;
    unique case (size)
      SZ_B: base = 8'h01;
      SZ_H: base = 8'h03;
      SZ_W: base = 8'h0F;
      SZ_D: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

  // Offset bits that must be zero for an access of the given size
  function automatic logic [2:0] alignMask(input access_size_t size);
    logic [2:0] m;
    m = 3'd0;
    unique case (size)
      SZ_B: m = 3'd0;
      SZ_H: m = 3'd1;
      SZ_W: m = 3'd3;
      SZ_D: m = 3'd7;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bus of the data memory.
//   master : issues reqValid/reqWrite/reqAddr/reqSize/reqUnsigned/writeData,
//            observes ready/readData/readValid/misaligned
//   slave  : the memory side of the same signals
interface data_memory_if #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned BITS  = 64
);

  localparam int unsigned BYTES      = BITS / 8;
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH * BYTES);

  logic                  reqValid;
  logic                  reqWrite;
  logic [ADDR_WIDTH-1:0] reqAddr;
  logic [1:0]            reqSize;
  logic                  reqUnsigned;
  logic [BITS-1:0]       writeData;
  logic                  ready;
  logic [BITS-1:0]       readData;
  logic                  readValid;
  logic                  misaligned;

  modport master (
    output reqValid, reqWrite, reqAddr, reqSize, reqUnsigned, writeData,
    input  ready, readData, readValid, misaligned
  );

  modport slave (
    input  reqValid, reqWrite, reqAddr, reqSize, reqUnsigned, writeData,
    output ready, readData, readValid, misaligned
  );

endinterface

// File: rtl/data_memory_load_extend.sv
// Load alignment and extension: selects the addressed byte/half/word/double
// of a memory word and sign- or zero-extends it to BITS.
//   word       : full memory word
//   offset     : byte offset inside the word
//   size       : access size
//   isUnsigned : 1 = zero-extend, 0 = sign-extend
//   result_c   : extended load value (combinational)
module load_extend
  import mem_pkg::*;
#(
  parameter int unsigned BITS = 64
) (
  input  logic [BITS-1:0]             word,
  input  logic [$clog2(BITS/8)-1:0]   offset,
  input  access_size_t                size,
  input  logic                        isUnsigned,
  output logic [BITS-1:0]             result_c
);

  logic [BITS-1:0] shifted;
  logic [63:0]     wide;
  logic [63:0]     ext;

  // Work at 64 bits so replication counts stay positive for both word widths
  always_comb begin
    shifted  = word >> {offset, 3'b000};
    wide     = 64'(shifted);
    ext      = wide;
    unique case (size)
      SZ_B: ext = {{56{~isUnsigned & wide[7]}},  wide[7:0]};
      SZ_H: ext = {{48{~isUnsigned & wide[15]}}, wide[15:0]};
      SZ_W: ext = {{32{~isUnsigned & wide[31]}}, wide[31:0]};
      SZ_D: ext = wide;
    endcase
    result_c = BITS'(ext);
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed data memory for the MEM stage.
// After reset it zeroes every word (one per cycle), then raises ready and
// serves byte/half/word/double loads and stores with a one-cycle registered
// read. Misaligned accesses change nothing and return a readValid pulse with
// misaligned set and readData zero.
//   clk  : rising-edge clock
//   rstN : synchronous active-low reset
//   bus  : request/response bus (slave side)
module data_memory
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned BITS  = 64
) (
  input  logic         clk,
  input  logic         rstN,
  data_memory_if.slave bus
);

  localparam int unsigned BYTES      = BITS / 8;
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH * BYTES);
  localparam int unsigned OFF_W      = $clog2(BYTES);
  localparam int unsigned IDX_W      = ADDR_WIDTH - OFF_W;

  state_t           state;
  state_t           stateNext;
  logic [IDX_W-1:0] initIdx;
  logic [IDX_W-1:0] initIdxNext;

  logic [BITS-1:0]  mem [DEPTH];

  logic [IDX_W-1:0] wordIdx;
  logic [OFF_W-1:0] offset;
  access_size_t     size;
  logic             accept;
  logic             legal;
  logic             storeEn;
  logic             sweepEn;
  logic [7:0]       lanes;
  logic [BITS-1:0]  wdShift;
  logic [BITS-1:0]  readWord;
  logic [BITS-1:0]  loadValue_c;

  logic             readyQ;
  logic             readValidQ;
  logic             misalignedQ;
  logic [BITS-1:0]  readDataQ;

  // Request decode
  always_comb begin
    wordIdx  = bus.reqAddr[ADDR_WIDTH-1:OFF_W];
    offset   = bus.reqAddr[OFF_W-1:0];
    size     = access_size_t'(bus.reqSize);
    accept   = bus.reqValid && (state == ST_RUN);
    // Doubles do not exist on a 32-bit word
    legal    = ((3'(offset) & alignMask(size)) == 3'd0) && !((size == SZ_D) && (BITS == 32));
    lanes    = laneMask(size, 3'(offset));
    wdShift  = bus.writeData << {offset, 3'b000};
    readWord = mem[wordIdx];
    storeEn  = rstN && accept && legal && bus.reqWrite;
    sweepEn  = rstN && (state == ST_INIT);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state   <= ST_INIT;
      initIdx <= '0;
    end else begin
      state   <= stateNext;
      initIdx <= initIdxNext;
    end
  end

  // Next state: sweep one word per cycle, then stay in RUN until reset
  always_comb begin
    stateNext   = state;
    initIdxNext = initIdx;
    unique case (state)
      ST_INIT: begin
        initIdxNext = initIdx + 1'b1;
        if (initIdx == IDX_W'(DEPTH - 1)) begin
          stateNext = ST_RUN;
        end
      end
      ST_RUN: stateNext = ST_RUN;
    endcase
  end

  // Storage: zero sweep during INIT, byte-lane stores during RUN
  always_ff @(posedge clk) begin
    if (sweepEn) begin
      mem[initIdx] <= '0;
    end else if (storeEn) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (lanes[b]) begin
          mem[wordIdx][8*b +: 8] <= wdShift[8*b +: 8];
        end
      end
    end
  end

  load_extend #(
    .BITS(BITS)
  ) uLoadExtend (
    .word      (readWord),
    .offset    (offset),
    .size      (size),
    .isUnsigned(bus.reqUnsigned),
    .result_c  (loadValue_c)
  );

  // Registered response; readData holds between pulses
  always_ff @(posedge clk) begin
    if (!rstN) begin
      readyQ      <= 1'b0;
      readValidQ  <= 1'b0;
      misalignedQ <= 1'b0;
      readDataQ   <= '0;
    end else begin
      readyQ      <= (stateNext == ST_RUN);
      readValidQ  <= 1'b0;
      misalignedQ <= 1'b0;
      if (accept) begin
        if (!legal) begin
          readValidQ  <= 1'b1;
          misalignedQ <= 1'b1;
          readDataQ   <= '0;
        end else if (!bus.reqWrite) begin
          readValidQ  <= 1'b1;
          readDataQ   <= loadValue_c;
        end
      end
    end
  end

  assign bus.ready      = readyQ;
  assign bus.readValid  = readValidQ;
  assign bus.misaligned = misalignedQ;
  assign bus.readData   = readDataQ;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: a byte-array reference model checked every cycle,
// plus directed requests with literal expected results.
module tb_data_memory;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned BITS  = 64;
  localparam int unsigned NBYTE = DEPTH * 8;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  data_memory_if #(.DEPTH(DEPTH), .BITS(BITS)) bus ();

  data_memory #(.DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chkOn = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: flat byte array, little-endian, rules applied directly
  logic [7:0]  mdl [NBYTE];
  bit          mReady;
  int          mInit;
  bit          mValid;
  bit          mMis;
  logic [63:0] mData;
  int          mN;
  int          mA;
  logic [63:0] mV;

  always @(posedge clk) begin
    if (!rstN) begin
      mReady = 1'b0;
      mInit  = 0;
      mValid = 1'b0;
      mMis   = 1'b0;
      mData  = '0;
    end else begin
      mValid = 1'b0;
      mMis   = 1'b0;
      if (!mReady) begin
        mInit++;
        if (mInit == DEPTH) begin
          mReady = 1'b1;
          for (int i = 0; i < NBYTE; i++) mdl[i] = 8'h00;
        end
      end else if (bus.reqValid) begin
        mN = 1 << bus.reqSize;
        mA = int'(bus.reqAddr);
        if ((mA % mN) != 0) begin
          mValid = 1'b1;
          mMis   = 1'b1;
          mData  = '0;
        end else if (bus.reqWrite) begin
          for (int i = 0; i < mN; i++) mdl[mA + i] = bus.writeData[8*i +: 8];
        end else begin
          mV = '0;
          for (int i = 0; i < mN; i++) mV[8*i +: 8] = mdl[mA + i];
          if (!bus.reqUnsigned && mV[8*mN - 1]) mV = mV | ~((64'd1 << (8*mN)) - 64'd1);
          mValid = 1'b1;
          mData  = mV;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chkOn) begin
      check("cmp_ready",      64'(bus.ready),      64'(mReady));
      check("cmp_readValid",  64'(bus.readValid),  64'(mValid));
      check("cmp_misaligned", 64'(bus.misaligned), 64'(mMis));
      check("cmp_readData",   bus.readData,        mData);
    end
  end

  task automatic drive(input logic w, input int a, input int s, input logic u, input logic [63:0] d);
    @(negedge clk);
    bus.reqValid    = 1'b1;
    bus.reqWrite    = w;
    bus.reqAddr     = 11'(a);
    bus.reqSize     = 2'(s);
    bus.reqUnsigned = u;
    bus.writeData   = d;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.reqValid = 1'b0;
  endtask

  // Literal check of the response produced by the request just driven
  task automatic expectOut(input string nm, input logic v, input logic m, input logic [63:0] d);
    @(posedge clk);
    #1;
    check({nm, "_valid"}, 64'(bus.readValid),  64'(v));
    check({nm, "_mis"},   64'(bus.misaligned), 64'(m));
    if (v) check({nm, "_data"}, bus.readData, d);
  endtask

  // Counts edges from release of reset until ready is seen high
  task automatic countInit(input string nm);
    int cnt;
    cnt = 0;
    @(negedge clk);
    rstN = 1'b1;
    while (cnt < 1000) begin
      @(posedge clk);
      cnt++;
      #1;
      if (bus.ready) break;
    end
    check(nm, 64'(cnt), 64'd256);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.reqValid    = 1'b0;
    bus.reqWrite    = 1'b0;
    bus.reqAddr     = '0;
    bus.reqSize     = '0;
    bus.reqUnsigned = 1'b0;
    bus.writeData   = '0;

    repeat (3) @(posedge clk);
    #1;
    chkOn = 1'b1;
    check("reset_ready", 64'(bus.ready), 64'd0);
    check("reset_valid", 64'(bus.readValid), 64'd0);

    countInit("init_cycles");
    drive(1'b0, 'h7F8, 3, 1'b0, '0);           expectOut("ld_top_zero", 1'b1, 1'b0, 64'h0);

    drive(1'b1, 'h10, 3, 1'b0, 64'h0123456789ABCDEF); expectOut("st_d", 1'b0, 1'b0, '0);
    drive(1'b0, 'h10, 3, 1'b0, '0);            expectOut("ld_d", 1'b1, 1'b0, 64'h0123456789ABCDEF);

    drive(1'b1, 'h13, 0, 1'b0, 64'h00000000000000AA); expectOut("st_b", 1'b0, 1'b0, '0);
    drive(1'b0, 'h10, 3, 1'b0, '0);            expectOut("ld_d_merge", 1'b1, 1'b0, 64'h01234567AAABCDEF);
    drive(1'b0, 'h13, 0, 1'b0, '0);            expectOut("ld_b_s", 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFAA);
    drive(1'b0, 'h13, 0, 1'b1, '0);            expectOut("ld_b_u", 1'b1, 1'b0, 64'h00000000000000AA);

    drive(1'b1, 'h20, 1, 1'b0, 64'h0000000000008001); expectOut("st_h", 1'b0, 1'b0, '0);
    drive(1'b0, 'h20, 1, 1'b0, '0);            expectOut("ld_h_s", 1'b1, 1'b0, 64'hFFFFFFFFFFFF8001);
    drive(1'b0, 'h20, 2, 1'b1, '0);            expectOut("ld_w_u", 1'b1, 1'b0, 64'h0000000000008001);
    drive(1'b0, 'h20, 2, 1'b0, '0);            expectOut("ld_w_s", 1'b1, 1'b0, 64'h0000000000008001);

    drive(1'b1, 'h22, 2, 1'b0, 64'h00000000DEADBEEF); expectOut("st_w_mis", 1'b1, 1'b1, 64'h0);
    drive(1'b0, 'h20, 3, 1'b0, '0);            expectOut("ld_after_mis", 1'b1, 1'b0, 64'h0000000000008001);
    drive(1'b0, 'h21, 1, 1'b0, '0);            expectOut("ld_h_mis", 1'b1, 1'b1, 64'h0);
    drive(1'b0, 'h14, 3, 1'b0, '0);            expectOut("ld_d_mis", 1'b1, 1'b1, 64'h0);

    drive(1'b0, 'h10, 3, 1'b1, '0);            expectOut("b2b_0", 1'b1, 1'b0, 64'h01234567AAABCDEF);
    drive(1'b0, 'h16, 1, 1'b0, '0);            expectOut("b2b_1", 1'b1, 1'b0, 64'h0000000000000123);
    drive(1'b0, 'h14, 2, 1'b0, '0);            expectOut("b2b_2", 1'b1, 1'b0, 64'h0000000001234567);
    idle();
    @(posedge clk);
    #1;
    check("hold_data",  bus.readData, 64'h0000000001234567);
    check("idle_valid", 64'(bus.readValid), 64'd0);

    // Load in flight, then reset on the following edge
    drive(1'b0, 'h10, 3, 1'b0, '0);
    @(negedge clk);
    rstN = 1'b0;
    bus.reqValid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_valid", 64'(bus.readValid), 64'd0);
    check("rst_mid_ready", 64'(bus.ready), 64'd0);
    check("rst_mid_data",  bus.readData, 64'd0);

    // A store held through the whole sweep must be ignored
    @(negedge clk);
    bus.reqValid    = 1'b1;
    bus.reqWrite    = 1'b1;
    bus.reqAddr     = 11'h30;
    bus.reqSize     = 2'd3;
    bus.writeData   = 64'hFFFFFFFFFFFFFFFF;
    countInit("reinit_cycles");
    drive(1'b0, 'h10, 3, 1'b0, '0);            expectOut("ld_after_rst", 1'b1, 1'b0, 64'h0);
    drive(1'b0, 'h30, 3, 1'b0, '0);            expectOut("ld_init_ignored", 1'b1, 1'b0, 64'h0);
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
